mem_port_master: RTL and testbench

MEM_PORT_MASTER -- requirements
Module: mem_port_master

---
 rtl/mem_port_master.sv | 180 ++++++++++++++++++
 tb/tb_mem_port_master.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_master.sv
// CPU load/store port onto a single-port 32-bit synchronous RAM; sub-word stores are read-modify-write.
// Latency: error 1, word store 2, load 2+RD_LATENCY, sub-word store 3+RD_LATENCY cycles; req_ready only in IDLE, no response backpressure.
module mem_port_master #(
    parameter int ADDR_W     = 10,
    parameter int RD_LATENCY = 1
) (
    input  logic              clka,
    input  logic              rstb,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_din,
    output logic              ram_en,
    output logic              ram_we,
    output logic              ram_regce,
    output logic              ram_rst,
    input  logic [31:0]       ram_dout
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] READ  = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] RESP  = 3'd4;

    localparam logic WAIT_LAST = (RD_LATENCY == 2);

    logic [2:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        off_q;
    logic [1:0]        size_q;
    logic              we_q;
    logic              sgn_q;
    logic [31:0]       wdata_q;
    logic [31:0]       din_q;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic              wcnt_q;
    logic              bad_req;
    logic              unused_addr_bits;

    // Upper address bits are dropped so accesses wrap modulo the RAM size.
    assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

    always_comb begin
        bad_req = 1'b0;
        case (req_size)
            2'b01:   bad_req = req_addr[0];
            2'b10:   bad_req = (req_addr[1:0] != 2'b00);
            2'b11:   bad_req = 1'b1;
            default: bad_req = 1'b0;
        endcase
    end

    // Big-endian lanes: offset 0 is the most significant byte.
    function automatic logic [31:0] merge_sub(input logic [31:0] w,
                                              input logic [31:0] d,
                                              input logic [1:0]  sz,
                                              input logic [1:0]  off);
        logic [31:0] r;
        r = w;
        if (sz == 2'b00) begin
            case (off)
                2'd0:    r[31:24] = d[7:0];
                2'd1:    r[23:16] = d[7:0];
                2'd2:    r[15:8]  = d[7:0];
                default: r[7:0]   = d[7:0];
            endcase
        end else if (sz == 2'b01) begin
            if (off[1]) r[15:0]  = d[15:0];
            else        r[31:16] = d[15:0];
        end
        return r;
    endfunction

    function automatic logic [31:0] extract_load(input logic [31:0] w,
                                                 input logic [1:0]  sz,
                                                 input logic [1:0]  off,
                                                 input logic        sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        h = off[1] ? w[15:0] : w[31:16];
        case (sz)
            2'b00:   r = {{24{sgn & b[7]}}, b};
            2'b01:   r = {{16{sgn & h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    always_ff @(posedge clka) begin
        if (rstb) begin
            state   <= IDLE;
            addr_q  <= '0;
            off_q   <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
            sgn_q   <= 1'b0;
            wdata_q <= '0;
            din_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            wcnt_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr[ADDR_W+1:2];
                        off_q   <= req_addr[1:0];
                        size_q  <= req_size;
                        we_q    <= req_we;
                        sgn_q   <= req_signed;
                        wdata_q <= req_wdata;
                        err_q   <= bad_req;
                        rdata_q <= '0;
                        if (bad_req) begin
                            state <= RESP;
                        end else if (req_we && req_size == 2'b10) begin
                            din_q <= req_wdata;
                            state <= WRITE;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    wcnt_q <= 1'b0;
                    state  <= WAIT;
                end
                WAIT: begin
                    if (wcnt_q == WAIT_LAST) begin
                        if (we_q) begin
                            din_q <= merge_sub(ram_dout, wdata_q, size_q, off_q);
                            state <= WRITE;
                        end else begin
                            rdata_q <= extract_load(ram_dout, size_q, off_q, sgn_q);
                            state   <= RESP;
                        end
                    end else begin
                        wcnt_q <= 1'b1;
                    end
                end
                WRITE: begin
                    rdata_q <= '0;
                    state   <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are gated by rstb so they read as zero for the whole reset cycle.
    assign req_ready = !rstb && (state == IDLE);
    assign rsp_valid = !rstb && (state == RESP);
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = rsp_valid ? rdata_q : '0;
    assign ram_en    = !rstb && (state == READ || state == WRITE);
    assign ram_we    = !rstb && (state == WRITE);
    assign ram_regce = !rstb && (state == WAIT);
    assign ram_rst   = rstb;
    assign ram_addr  = rstb ? '0 : addr_q;
    assign ram_din   = rstb ? '0 : din_q;

endmodule

// File: tb/tb_mem_port_master.sv
// Bench for mem_port_master: two instances (RD_LATENCY 1 and 2), each on its own RAM model, checked against a behavioural memory model.
module tb_mem_port_master;
    localparam int N = 2;

    logic clka = 1'b0;
    always #5 clka = ~clka;

    logic        rstb;
    logic        req_valid[N], req_ready[N], req_we[N], req_signed[N];
    logic [1:0]  req_size[N];
    logic [31:0] req_addr[N], req_wdata[N];
    logic        rsp_valid[N], rsp_err[N];
    logic [31:0] rsp_rdata[N], ram_din[N], ram_dout[N];
    logic [9:0]  ram_addr[N];
    logic        ram_en[N], ram_we[N], ram_regce[N], ram_rst[N];

    int passed = 0;
    int total  = 0;

    mem_port_master #(.ADDR_W(10), .RD_LATENCY(1)) u_lat1 (
        .clka(clka), .rstb(rstb),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_size(req_size[0]), .req_signed(req_signed[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0]), .ram_addr(ram_addr[0]), .ram_din(ram_din[0]),
        .ram_en(ram_en[0]), .ram_we(ram_we[0]), .ram_regce(ram_regce[0]),
        .ram_rst(ram_rst[0]), .ram_dout(ram_dout[0])
    );

    mem_port_master #(.ADDR_W(10), .RD_LATENCY(2)) u_lat2 (
        .clka(clka), .rstb(rstb),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_size(req_size[1]), .req_signed(req_signed[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1]), .ram_addr(ram_addr[1]), .ram_din(ram_din[1]),
        .ram_en(ram_en[1]), .ram_we(ram_we[1]), .ram_regce(ram_regce[1]),
        .ram_rst(ram_rst[1]), .ram_dout(ram_dout[1])
    );

    // RAM models: lane 0 is a plain registered read, lane 1 adds an output register.
    logic [31:0] mem [N][1024];
    logic [31:0] stage1[N], stage2[N];
    int          we_cnt[N] = '{0, 0};
    int          en_cnt[N] = '{0, 0};
    logic [9:0]  last_waddr[N];
    logic [31:0] last_wdin[N];

    always @(posedge clka) begin
        for (int g = 0; g < N; g++) begin
            if (ram_en[g]) begin
                en_cnt[g] <= en_cnt[g] + 1;
                if (ram_we[g]) begin
                    mem[g][ram_addr[g]] <= ram_din[g];
                    we_cnt[g]           <= we_cnt[g] + 1;
                    last_waddr[g]       <= ram_addr[g];
                    last_wdin[g]        <= ram_din[g];
                end else begin
                    stage1[g] <= mem[g][ram_addr[g]];
                end
            end
            if (ram_rst[g])        stage2[g] <= '0;
            else if (ram_regce[g]) stage2[g] <= stage1[g];
        end
    end
    assign ram_dout[0] = stage1[0];
    assign ram_dout[1] = stage2[1];

    logic [31:0] ref_mem [N][1024];

    // Behavioural model: expected response, latency and memory effect of one request.
    task automatic model_op(input int g, input logic we, input logic [1:0] sz, input logic sg,
                            input logic [31:0] a, input logic [31:0] wd,
                            output logic [31:0] rd, output logic er, output int lat);
        int          idx, off, sh;
        logic [31:0] w, m;
        logic [7:0]  b;
        logic [15:0] h;
        idx = int'(a[11:2]);
        off = int'(a[1:0]);
        w   = ref_mem[g][idx];
        er  = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && off != 0);
        rd  = '0;
        if (er) begin
            lat = 1;
        end else if (!we) begin
            lat = 2 + (g + 1);
            if (sz == 2'd0) begin
                b  = 8'(w >> (8 * (3 - off)));
                rd = {{24{sg & b[7]}}, b};
            end else if (sz == 2'd1) begin
                h  = 16'(w >> (16 * (1 - off / 2)));
                rd = {{16{sg & h[15]}}, h};
            end else begin
                rd = w;
            end
        end else if (sz == 2'd2) begin
            lat = 2;
            ref_mem[g][idx] = wd;
        end else begin
            lat = 3 + (g + 1);
            sh = (sz == 2'd0) ? 8 * (3 - off) : 16 * (1 - off / 2);
            m  = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
            ref_mem[g][idx] = (w & ~m) | ((wd << sh) & m);
        end
    endtask

    // Issue one request on lane g and report what came back (lat = -1 on timeout).
    task automatic do_req(input int g, input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic er);
        int c;
        @(negedge clka);
        c = 0;
        while (!req_ready[g] && c < 20) begin
            @(negedge clka);
            c++;
        end
        req_valid[g] = 1'b1; req_we[g] = we; req_size[g] = sz;
        req_signed[g] = sg; req_addr[g] = a; req_wdata[g] = wd;
        @(negedge clka);
        req_valid[g] = 1'b0;
        lat = -1; rd = '0; er = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (rsp_valid[g]) begin
                lat = k; rd = rsp_rdata[g]; er = rsp_err[g];
                break;
            end
            @(negedge clka);
        end
    endtask

    task automatic test_reset();
        rstb = 1'b1;
        for (int g = 0; g < N; g++) begin
            req_valid[g] = 1'b0; req_we[g] = 1'b0; req_size[g] = 2'd0;
            req_signed[g] = 1'b0; req_addr[g] = '0; req_wdata[g] = '0;
        end
        repeat (3) @(negedge clka);
        for (int g = 0; g < N; g++) begin
            total++;
            if ({req_ready[g], ram_rst[g], rsp_valid[g], rsp_err[g], ram_en[g], ram_we[g], ram_regce[g]} !== 7'b0100000)
                $display("FAIL reset_ctrl lane%0d: got %b want 0100000", g,
                         {req_ready[g], ram_rst[g], rsp_valid[g], rsp_err[g], ram_en[g], ram_we[g], ram_regce[g]});
            else passed++;
            total++;
            if ({rsp_rdata[g], ram_addr[g], ram_din[g]} !== 74'd0)
                $display("FAIL reset_data lane%0d: got %h want 0", g, {rsp_rdata[g], ram_addr[g], ram_din[g]});
            else passed++;
        end
        rstb = 1'b0;
        @(posedge clka);
        #1;
        for (int g = 0; g < N; g++) begin
            total++;
            if (req_ready[g] !== 1'b1 || ram_rst[g] !== 1'b0)
                $display("FAIL ready_after_reset lane%0d: got ready=%b rst=%b want 1 0", g, req_ready[g], ram_rst[g]);
            else passed++;
        end
    endtask

    typedef struct packed {
        logic        we;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        er;
    } dreq_t;

    task automatic test_directed(input int g);
        dreq_t       dt[10];
        logic [31:0] mrd, rd;
        logic        mer, er;
        int          mlat, lat, en_before;
        dt[0] = '{1'b1, 2'd2, 1'b0, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0};
        dt[1] = '{1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0};
        dt[2] = '{1'b1, 2'd0, 1'b0, 32'h11,   32'h0000005A, 32'h0,        1'b0};
        dt[3] = '{1'b0, 2'd0, 1'b1, 32'h13,   32'h0,        32'hFFFFFFEF, 1'b0};
        dt[4] = '{1'b0, 2'd0, 1'b0, 32'h13,   32'h0,        32'h000000EF, 1'b0};
        dt[5] = '{1'b1, 2'd2, 1'b0, 32'h14,   32'h12348001, 32'h0,        1'b0};
        dt[6] = '{1'b0, 2'd1, 1'b1, 32'h16,   32'h0,        32'hFFFF8001, 1'b0};
        dt[7] = '{1'b0, 2'd1, 1'b0, 32'h16,   32'h0,        32'h00008001, 1'b0};
        dt[8] = '{1'b0, 2'd1, 1'b0, 32'h13,   32'h0,        32'h0,        1'b1};
        dt[9] = '{1'b1, 2'd2, 1'b0, 32'h1000, 32'hCAFEF00D, 32'h0,        1'b0};
        for (int i = 0; i < 10; i++) begin
            model_op(g, dt[i].we, dt[i].sz, dt[i].sg, dt[i].a, dt[i].wd, mrd, mer, mlat);
            en_before = en_cnt[g];
            do_req(g, dt[i].we, dt[i].sz, dt[i].sg, dt[i].a, dt[i].wd, lat, rd, er);
            total++;
            if (lat !== mlat || rd !== dt[i].rd || er !== dt[i].er)
                $display("FAIL directed%0d lane%0d: got lat=%0d rd=%h err=%b want lat=%0d rd=%h err=%b",
                         i, g, lat, rd, er, mlat, dt[i].rd, dt[i].er);
            else passed++;
            if (i == 2) begin
                total++;
                if (last_wdin[g] !== 32'hDE5ABEEF || last_waddr[g] !== 10'd4)
                    $display("FAIL byte_merge lane%0d: got %h@%0d want DE5ABEEF@4", g, last_wdin[g], last_waddr[g]);
                else passed++;
            end
            if (i == 8) begin
                total++;
                if (en_cnt[g] !== en_before)
                    $display("FAIL err_no_ram lane%0d: got %0d enables want 0", g, en_cnt[g] - en_before);
                else passed++;
            end
            if (i == 9) begin
                total++;
                if (last_waddr[g] !== 10'd0 || last_wdin[g] !== 32'hCAFEF00D)
                    $display("FAIL wrap lane%0d: got %h@%0d want CAFEF00D@0", g, last_wdin[g], last_waddr[g]);
                else passed++;
            end
        end
    endtask

    task automatic test_random(input int g);
        logic [31:0] mrd, rd, a, wd;
        logic        mer, er, we, sg;
        logic [1:0]  sz;
        int          mlat, lat, en_before;
        for (int idx = 0; idx < 16; idx++) begin
            wd = $urandom;
            model_op(g, 1'b1, 2'd2, 1'b0, idx * 4, wd, mrd, mer, mlat);
            do_req(g, 1'b1, 2'd2, 1'b0, idx * 4, wd, lat, rd, er);
            total++;
            if (lat !== mlat || rd !== mrd || er !== mer)
                $display("FAIL preload%0d lane%0d: got lat=%0d rd=%h err=%b want lat=%0d rd=%h err=%b",
                         idx, g, lat, rd, er, mlat, mrd, mer);
            else passed++;
        end
        for (int i = 0; i < 60; i++) begin
            we = 1'($urandom);
            sg = 1'($urandom);
            sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = ($urandom_range(0, 1) ? ($urandom << 12) : 32'h0) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            wd = $urandom;
            model_op(g, we, sz, sg, a, wd, mrd, mer, mlat);
            en_before = en_cnt[g];
            do_req(g, we, sz, sg, a, wd, lat, rd, er);
            total++;
            if (lat !== mlat || rd !== mrd || er !== mer)
                $display("FAIL random%0d lane%0d a=%h we=%b sz=%0d: got lat=%0d rd=%h err=%b want lat=%0d rd=%h err=%b",
                         i, g, a, we, sz, lat, rd, er, mlat, mrd, mer);
            else passed++;
            if (mer) begin
                total++;
                if (en_cnt[g] !== en_before)
                    $display("FAIL random_err_ram%0d lane%0d: got %0d enables want 0", i, g, en_cnt[g] - en_before);
                else passed++;
            end
        end
        for (int idx = 0; idx < 16; idx++) begin
            total++;
            if (mem[g][idx] !== ref_mem[g][idx])
                $display("FAIL ram_word%0d lane%0d: got %h want %h", idx, g, mem[g][idx], ref_mem[g][idx]);
            else passed++;
        end
    endtask

    task automatic test_reset_mid(input int g);
        int          we_before, rsp_seen, lat, mlat;
        logic [31:0] rd, mrd, word_before;
        logic        er, mer;
        we_before   = we_cnt[g];
        word_before = mem[g][8];
        rsp_seen    = 0;
        @(negedge clka);
        req_valid[g] = 1'b1; req_we[g] = 1'b1; req_size[g] = 2'd0;
        req_signed[g] = 1'b0; req_addr[g] = 32'h21; req_wdata[g] = 32'h77;
        @(negedge clka);
        req_valid[g] = 1'b0;
        @(negedge clka);
        total++;
        if (ram_regce[g] !== 1'b1)
            $display("FAIL mid_reset_in_wait lane%0d: got regce=%b want 1", g, ram_regce[g]);
        else passed++;
        rstb = 1'b1;
        @(negedge clka);
        rstb = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clka);
            if (rsp_valid[g]) rsp_seen++;
        end
        total++;
        if (rsp_seen !== 0 || we_cnt[g] !== we_before || mem[g][8] !== word_before)
            $display("FAIL mid_reset_abandon lane%0d: got rsp=%0d writes=%0d want 0 0", g, rsp_seen, we_cnt[g] - we_before);
        else passed++;
        model_op(g, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, mrd, mer, mlat);
        do_req(g, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, lat, rd, er);
        total++;
        if (lat !== mlat || rd !== mrd || er !== mer)
            $display("FAIL after_reset_load lane%0d: got lat=%0d rd=%h err=%b want lat=%0d rd=%h err=%b",
                     g, lat, rd, er, mlat, mrd, mer);
        else passed++;
    endtask

    task automatic test_back_to_back(input int g);
        localparam int NR = 6;
        logic        bwe[NR], bsg[NR];
        logic [1:0]  bsz[NR];
        logic [31:0] ba[NR], bwd[NR];
        logic [31:0] exp_rd[$], mrd, erd;
        logic        exp_er[$], mer, eer;
        int          acc_c[$], exp_lat[$], mlat, elat, ac, c, i;
        for (int k = 0; k < NR; k++) begin
            bwe[k] = 1'($urandom);
            bsg[k] = 1'($urandom);
            bsz[k] = (k == 3) ? 2'd3 : 2'($urandom_range(0, 2));
            ba[k]  = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            bwd[k] = $urandom;
        end
        i = 0;
        c = 0;
        @(negedge clka);
        while ((i < NR || acc_c.size() > 0) && c < 300) begin
            if (rsp_valid[g]) begin
                total++;
                if (acc_c.size() == 0) begin
                    $display("FAIL b2b_extra_rsp lane%0d: got response at %0d want none", g, c);
                end else begin
                    ac = acc_c.pop_front(); erd = exp_rd.pop_front();
                    eer = exp_er.pop_front(); elat = exp_lat.pop_front();
                    if (c - ac !== elat || rsp_rdata[g] !== erd || rsp_err[g] !== eer)
                        $display("FAIL b2b_rsp lane%0d: got lat=%0d rd=%h err=%b want lat=%0d rd=%h err=%b",
                                 g, c - ac, rsp_rdata[g], rsp_err[g], elat, erd, eer);
                    else passed++;
                end
            end
            if (i < NR) begin
                req_valid[g] = 1'b1; req_we[g] = bwe[i]; req_size[g] = bsz[i];
                req_signed[g] = bsg[i]; req_addr[g] = ba[i]; req_wdata[g] = bwd[i];
                if (req_ready[g]) begin
                    model_op(g, bwe[i], bsz[i], bsg[i], ba[i], bwd[i], mrd, mer, mlat);
                    acc_c.push_back(c); exp_rd.push_back(mrd);
                    exp_er.push_back(mer); exp_lat.push_back(mlat);
                    i++;
                end
            end else begin
                req_valid[g] = 1'b0;
            end
            @(negedge clka);
            c++;
        end
        req_valid[g] = 1'b0;
        total++;
        if (i !== NR || acc_c.size() !== 0)
            $display("FAIL b2b_complete lane%0d: got accepted=%0d outstanding=%0d want %0d 0", g, i, acc_c.size(), NR);
        else passed++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        for (int g = 0; g < N; g++) test_directed(g);
        for (int g = 0; g < N; g++) test_random(g);
        for (int g = 0; g < N; g++) test_reset_mid(g);
        for (int g = 0; g < N; g++) test_back_to_back(g);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
